// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - NCO-style multi-channel clock-enable generator with settle/lock FSM
// Optional mid-period enable output ce_half is built when CLKEN_HALF_PHASE_EN is defined.
module clken_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    cfg_load,
    input  logic [NUM_CH*ACC_W-1:0] inc_in,
    output logic [NUM_CH-1:0]       ce,
`ifdef CLKEN_HALF_PHASE_EN
    output logic [NUM_CH-1:0]       ce_half,
`endif
    output logic                    locked
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] settle_cnt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == CNT_LAST) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        // A configuration load restarts the whole settle period from any state.
        if (cfg_load) begin
            state_nxt = SETTLE;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else begin
            locked <= (state_nxt == RUN);
            if (cfg_load || state != SETTLE) begin
                settle_cnt <= '0;
            end else if (settle_cnt != CNT_LAST) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             ce_q;

        assign sum = {1'b0, acc} + {1'b0, inc};

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                inc  <= '0;
                acc  <= '0;
                ce_q <= 1'b0;
            end else if (cfg_load) begin
                inc  <= inc_in[g*ACC_W +: ACC_W];
                acc  <= '0;
                ce_q <= 1'b0;
            end else if (state == RUN) begin
                acc  <= sum[ACC_W-1:0];
                ce_q <= sum[ACC_W];
            end else begin
                acc  <= '0;
                ce_q <= 1'b0;
            end
        end

        // A pulse already registered must not leak out while a reload is being sampled.
        assign ce[g] = ce_q & ~cfg_load;

`ifdef CLKEN_HALF_PHASE_EN
        logic half_q;

        // Crossing the midpoint without wrap is exactly MSB rising from 0 to 1.
        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                half_q <= 1'b0;
            end else if (!cfg_load && state == RUN) begin
                half_q <= ~acc[ACC_W-1] & sum[ACC_W-1];
            end else begin
                half_q <= 1'b0;
            end
        end

        assign ce_half[g] = half_q & ~cfg_load;
`endif
    end

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - table-driven self-checking bench for clken_gen (ACC_W=8, LOCK_CYCLES=4)
module tb_clken_gen;

    localparam int NUM_CH      = 2;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 4;

    logic                    refclk = 1'b0;
    logic                    rst_n;
    logic                    cfg_load;
    logic [NUM_CH*ACC_W-1:0] inc_in;
    logic [NUM_CH-1:0]       ce;
    logic                    locked;
`ifdef CLKEN_HALF_PHASE_EN
    logic [NUM_CH-1:0]       ce_half;
`endif

    clken_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg_load (cfg_load),
        .inc_in   (inc_in),
        .ce       (ce),
`ifdef CLKEN_HALF_PHASE_EN
        .ce_half  (ce_half),
`endif
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [7:0] inc0;
        logic [7:0] inc1;
        int         n;
        int         exp0;
        int         exp1;
        int         first0;
    } vec_t;

    vec_t vecs[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] i0, input logic [7:0] i1);
        @(negedge refclk);
        cfg_load = 1'b1;
        inc_in   = {i1, i0};
        @(negedge refclk);
        cfg_load = 1'b0;
        inc_in   = 16'($urandom);
    endtask

    // Called in SETTLE cycle 0; returns in RUN cycle 0.
    task automatic wait_lock(input string tag);
        for (int k = 0; k < LOCK_CYCLES; k++) begin
            check({tag, "_settle"}, int'({locked, ce}), 0);
            @(negedge refclk);
        end
        check({tag, "_locked"}, int'(locked), 1);
        check({tag, "_ce_run0"}, int'(ce), 0);
    endtask

    task automatic run_count(input int n, output int c0, output int c1, output int first0);
        c0 = 0;
        c1 = 0;
        first0 = -1;
        for (int c = 0; c < n; c++) begin
            if (ce[0]) begin
                c0++;
                if (first0 < 0) first0 = c;
            end
            if (ce[1]) c1++;
            @(negedge refclk);
        end
    endtask

    initial begin
        int c0, c1, f0;

        vecs[0] = '{inc0: 8'd64,  inc1: 8'd0,   n: 16,  exp0: 3,   exp1: 0,   first0: 4};
        vecs[1] = '{inc0: 8'd96,  inc1: 8'd64,  n: 16,  exp0: 5,   exp1: 3,   first0: 3};
        vecs[2] = '{inc0: 8'd255, inc1: 8'd128, n: 257, exp0: 255, exp1: 128, first0: 2};
        vecs[3] = '{inc0: 8'd1,   inc1: 8'd255, n: 16,  exp0: 0,   exp1: 14,  first0: -1};
        vecs[4] = '{inc0: 8'd0,   inc1: 8'd0,   n: 16,  exp0: 0,   exp1: 0,   first0: -1};
        vecs[5] = '{inc0: 8'd160, inc1: 8'd32,  n: 16,  exp0: 9,   exp1: 1,   first0: 2};

        rst_n    = 1'b0;
        cfg_load = 1'b0;
        inc_in   = '0;
        #1;
        check("reset_ce", int'(ce), 0);
        check("reset_locked", int'(locked), 0);
        repeat (3) @(negedge refclk);
        check("reset_hold", int'({locked, ce}), 0);

        // Load on the very first cycle after reset release.
        rst_n    = 1'b1;
        cfg_load = 1'b1;
        inc_in   = {8'd0, 8'd64};
        @(negedge refclk);
        cfg_load = 1'b0;
        inc_in   = 16'hffff;
        wait_lock("first_load");
        run_count(16, c0, c1, f0);
        check("first_load_ce0", c0, 3);
        check("first_load_first0", f0, 4);
        check("first_load_ce1", c1, 0);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].inc0, vecs[v].inc1);
            wait_lock($sformatf("vec%0d", v));
            run_count(vecs[v].n, c0, c1, f0);
            check($sformatf("vec%0d_ce0_count", v), c0, vecs[v].exp0);
            check($sformatf("vec%0d_ce1_count", v), c1, vecs[v].exp1);
            check($sformatf("vec%0d_ce0_first", v), f0, vecs[v].first0);
        end

        // inc=96: steady-state window of 8 RUN cycles holds exactly 3 pulses.
        load(8'd96, 8'd0);
        wait_lock("rate96");
        run_count(8, c0, c1, f0);
        run_count(8, c0, c1, f0);
        check("rate96_window", c0, 3);
        check("rate96_window_first", f0, 0);

        // Reload two cycles before lock would rise restarts the full settle count.
        load(8'd64, 8'd0);
        repeat (2) @(negedge refclk);
        check("restart_pre", int'({locked, ce}), 0);
        cfg_load = 1'b1;
        inc_in   = {8'd0, 8'd64};
        @(negedge refclk);
        cfg_load = 1'b0;
        wait_lock("restart");

        // Reload sampled while a pulse is registered: ce held low that cycle and next.
        load(8'd128, 8'd0);
        wait_lock("mask");
        repeat (2) @(negedge refclk);
        check("mask_pulse_pre", int'(ce[0]), 1);
        cfg_load = 1'b1;
        inc_in   = {8'd0, 8'd128};
        #1;
        check("mask_ce_load_cycle", int'(ce), 0);
        @(negedge refclk);
        cfg_load = 1'b0;
        check("mask_ce_after", int'(ce), 0);
        check("mask_locked_drop", int'(locked), 0);
        for (int k = 1; k < LOCK_CYCLES; k++) @(negedge refclk);
        @(negedge refclk);
        check("mask_relock", int'(locked), 1);
        repeat (2) @(negedge refclk);

        // Asynchronous reset mid-RUN while ce is high.
        check("areset_pre_ce", int'(ce[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_ce", int'(ce), 0);
        check("areset_locked", int'(locked), 0);
        @(negedge refclk);
        rst_n = 1'b1;
        @(negedge refclk);
        wait_lock("post_reset");
        run_count(16, c0, c1, f0);
        check("post_reset_ce0", c0, 0);
        check("post_reset_ce1", c1, 0);

`ifdef CLKEN_HALF_PHASE_EN
        begin
            logic ce_hist[20];
            logic half_hist[20];
            int   nh;
            load(8'd64, 8'd0);
            wait_lock("half");
            nh = 0;
            for (int c = 0; c < 20; c++) begin
                ce_hist[c]   = ce[0];
                half_hist[c] = ce_half[0];
                if (ce_half[0]) nh++;
                @(negedge refclk);
            end
            check("half_count", nh, 5);
            check("half_first", int'(half_hist[2]), 1);
            for (int c = 0; c < 18; c++) begin
                if (ce_hist[c]) check($sformatf("half_after_ce%0d", c), int'(half_hist[c+2]), 1);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clken_gen.md
CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 24, meaning phase-accumulator width in bits (8..32).
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, meaning settle cycles before locked asserts (1..65535).
REQ-004 SHALL have port refclk  input  1  the single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port cfg_load  input  1  single-cycle strobe that latches inc_in.
REQ-007 SHALL have port inc_in  input  NUM_CH*ACC_W  per-channel phase increment; channel i occupies bits [i*ACC_W +: ACC_W].
REQ-008 SHALL have port ce  output  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-009 SHALL have port locked  output  1  high when all channels run at the configured rate.

Function
REQ-010 SHALL hold one shadow increment register inc[i] and one accumulator acc[i] per channel, each ACC_W bits.
REQ-011 SHALL use a control FSM with states IDLE, SETTLE and RUN.
REQ-012 SHALL go IDLE->SETTLE on the first refclk edge after reset release, with settle counter = 0.
REQ-013 SHALL go SETTLE->RUN when the settle counter reaches LOCK_CYCLES-1, with locked = 1 from the cycle RUN is entered.
REQ-014 SHALL, in RUN, update acc[i] <= acc[i] + inc[i] modulo 2^ACC_W every cycle.
REQ-015 SHALL drive ce[i] high for exactly one cycle, registered, in the cycle after acc[i] + inc[i] carries out of bit ACC_W-1.
REQ-016 SHALL give an average ce[i] rate of f_refclk * inc[i] / 2^ACC_W; inc[i] = 0 -> ce[i] never asserts.
REQ-017 SHALL, in IDLE and SETTLE, hold all acc[i] = 0, all ce = 0 and locked = 0.
REQ-018 SHALL, on cfg_load = 1 in any state, latch inc_in into inc[], clear all accumulators and the settle counter, drop locked in the next cycle and enter SETTLE.
REQ-019 SHALL treat cfg_load during SETTLE as a restart: the full LOCK_CYCLES count begins again.
REQ-020 SHALL keep all channels phase-aligned after every cfg_load (common zero start).
REQ-021 SHALL keep ce[i] at 0 in the cycle cfg_load is sampled and in the cycle after it.
REQ-022 SHALL sample inc_in only when cfg_load = 1; inc_in changes at other times have no effect.

Reset
REQ-023 SHALL, with rst_n low, asynchronously force: FSM = IDLE, inc[] = 0, acc[] = 0, settle counter = 0, ce = 0, locked = 0.
REQ-024 SHALL resume from IDLE on reset release; rst_n low mid-RUN or mid-SETTLE aborts immediately, and locked falls without waiting for a clock edge.
REQ-025 SHALL, when cfg_load = 1 on the first cycle after reset release, load inc_in and enter SETTLE as in REQ-018.

Configuration
REQ-026 SHALL, when macro CLKEN_HALF_PHASE_EN is defined, add output ce_half (NUM_CH bits): a one-cycle pulse in the cycle after acc[i] crosses from below 2^(ACC_W-1) to at or above it, giving a mid-period enable for dual-edge logic.
REQ-027 SHALL, without CLKEN_HALF_PHASE_EN, omit port ce_half and all related logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: ACC_W=8, LOCK_CYCLES=4, cfg_load with inc={64,0} -> locked=1 4 cycles after SETTLE entry, then ce[0] pulses every 4th cycle and ce[1] stays 0.
REQ-029 SHALL cover: ACC_W=8, inc[0]=96 -> exactly 3 ce[0] pulses per 8 RUN cycles, in a repeating pattern.
REQ-030 SHALL cover: cfg_load reissued 2 cycles before locked would rise -> locked stays 0 for a further full LOCK_CYCLES, with no ce pulses.
REQ-031 SHALL cover: rst_n pulled low mid-RUN between edges -> ce=0 and locked=0 asynchronously; after release, IDLE->SETTLE with inc=0.
REQ-032 SHALL cover: ACC_W=8, inc[0]=255 -> ce[0] high on 255 of every 256 RUN cycles.
REQ-033 SHALL cover, with CLKEN_HALF_PHASE_EN: ACC_W=8, inc=64 -> ce_half[0] pulses exactly 2 cycles after each ce[0] pulse.
